// File: rtl/overlay_fetch_blend.sv
// rtl/overlay_fetch_blend.sv - SDRAM overlay prefetch FIFO and beam compositor
//
// Streams RGBA4444 overlay words from SDRAM into a prefetch FIFO. On each
// active-video ce_pix it pops one word and composites it with the vector
// beam colour.
//
// Optional feature macro: OVERLAY_TINT_EN (builds the mode[2] white-tint path).
//
// Parameters:
//   ADDR_W      SDRAM byte-address width
//   FIFO_DEPTH  prefetch depth in 16-bit words (power of two, 4..256)
//   BASE_ADDR   byte address of the first overlay pixel (even)
//
// Ports:
//   clk_sys              system clock, rising edge
//   reset                asynchronous active-high reset
//   enable               overlay present; 0 flushes and blanks the background
//   ce_pix               pixel-rate enable
//   hblank, vblank       blanking; active video is ~(hblank|vblank)
//   mem_rd               one-cycle read request pulse
//   mem_addr             read address, held until mem_ready
//   mem_ready, mem_data  read response pulse and pixel word {a,b,g,r}
//   fg_r, fg_g, fg_b     beam colour
//   mode                 [0] alpha-darken, [1] overlay-coloured beam, [2] tint
//   out_r, out_g, out_b  registered composited pixel
//   underflow            sticky empty-pop flag, cleared at frame restart
`timescale 1ns/1ps
module overlay_fetch_blend #(
   parameter int                ADDR_W     = 25,
   parameter int                FIFO_DEPTH = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              enable,
   input  logic              ce_pix,
   input  logic              hblank,
   input  logic              vblank,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [15:0]       mem_data,
   input  logic [7:0]        fg_r,
   input  logic [7:0]        fg_g,
   input  logic [7:0]        fg_b,
   input  logic [2:0]        mode,
   output logic [7:0]        out_r,
   output logic [7:0]        out_g,
   output logic [7:0]        out_b,
   output logic              underflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

   // {c,c} maps 4-bit 0..15 onto 8-bit 0..255 exactly.
   function automatic logic [7:0] expand(input logic [3:0] c);
      return {c, c};
   endfunction

   // Rounded c*a/15, done as (c*a*17+128)>>8 to avoid a divider.
   function automatic logic [3:0] alpha_scale(input logic [3:0] c, input logic [3:0] a);
      logic [11:0] prod;
      prod = {8'h00, c} * {8'h00, a} * 12'd17 + 12'd128;
      return prod[11:8];
   endfunction

   function automatic logic [7:0] blend_ch(
      input logic [3:0] c,
      input logic [3:0] a,
      input logic [7:0] fg_c,
      input logic       fg_active,
      input logic       bg_present,
      input logic [1:0] mode_lo
   );
      logic [7:0] res;
      if (!fg_active)
         res = mode_lo[0] ? expand(alpha_scale(c, a)) : expand(c);
      else if (mode_lo[1] && bg_present)
         res = expand(c);
      else
         res = fg_c;
      return res;
   endfunction

`ifdef OVERLAY_TINT_EN
   // Moves x three quarters of the way to white; x + 0.75*(255-x) <= 255.
   function automatic logic [7:0] tint(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'd255 - x;
      return x + {1'b0, inv[7:1]} + {2'b00, inv[7:2]};
   endfunction
`endif

   // FIFO storage and bookkeeping
   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // Fetch state
   logic outstanding;
   logic stale;
   logic vblank_q;

   logic active;
   logic restart;
   logic pop;
   logic fifo_empty;
   logic do_pop;
   logic take_resp;
   logic push;
   logic flush;
   logic issue;

   assign active     = ~(hblank | vblank);
   assign restart    = ce_pix & vblank & ~vblank_q;
   assign pop        = ce_pix & active & enable;
   assign fifo_empty = (count == '0);
   assign do_pop     = pop & ~fifo_empty;
   // A response only counts if a read is actually outstanding; a response
   // landing on the restart edge belongs to the old frame and is dropped.
   assign take_resp  = mem_ready & outstanding;
   assign push       = take_resp & ~stale & ~restart & enable;
   assign flush      = restart | ~enable;
   assign issue      = enable & ~outstanding & (count < DEPTH_C);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mem_rd      <= 1'b0;
         mem_addr    <= BASE_ADDR;
         outstanding <= 1'b0;
         stale       <= 1'b0;
      end else begin
         mem_rd <= issue;
         if (issue)
            outstanding <= 1'b1;
         else if (take_resp)
            outstanding <= 1'b0;

         // A read still in flight at restart must not land in the new frame.
         if (take_resp)
            stale <= 1'b0;
         else if (restart && outstanding)
            stale <= 1'b1;

         if (restart)
            mem_addr <= BASE_ADDR;
         else if (push)
            mem_addr <= mem_addr + ADDR_STEP;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_data;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         vblank_q  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ce_pix)
            vblank_q <= vblank;
         if (restart)
            underflow <= 1'b0;
         else if (pop && fifo_empty)
            underflow <= 1'b1;
      end
   end

   // Compositing; an empty pop or a disabled overlay shows word 0.
   logic [15:0] pix_word;
   logic        fg_on;
   logic        bg_nz;
   logic [7:0]  next_r;
   logic [7:0]  next_g;
   logic [7:0]  next_b;

   assign pix_word = do_pop ? fifo_mem[rd_ptr] : 16'h0000;
   assign fg_on    = |{fg_r, fg_g, fg_b};
   assign bg_nz    = |pix_word[11:0];

   always_comb begin
      next_r = blend_ch(pix_word[3:0],  pix_word[15:12], fg_r, fg_on, bg_nz, mode[1:0]);
      next_g = blend_ch(pix_word[7:4],  pix_word[15:12], fg_g, fg_on, bg_nz, mode[1:0]);
      next_b = blend_ch(pix_word[11:8], pix_word[15:12], fg_b, fg_on, bg_nz, mode[1:0]);
`ifdef OVERLAY_TINT_EN
      // Only a bright beam (judged on red) is pushed toward white.
      if (fg_on && mode[2] && (fg_r > 8'd108)) begin
         next_r = tint(next_r);
         next_g = tint(next_g);
         next_b = tint(next_b);
      end
`endif
   end

`ifndef OVERLAY_TINT_EN
   logic unused_tint_mode;
   assign unused_tint_mode = mode[2];
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         out_r <= 8'h00;
         out_g <= 8'h00;
         out_b <= 8'h00;
      end else if (ce_pix) begin
         if (active) begin
            out_r <= next_r;
            out_g <= next_g;
            out_b <= next_b;
         end else begin
            out_r <= 8'h00;
            out_g <= 8'h00;
            out_b <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_overlay_fetch_blend.sv
// tb/tb_overlay_fetch_blend.sv - self-checking bench for overlay_fetch_blend
`timescale 1ns/1ps
module tb_overlay_fetch_blend;

   localparam int          ADDR_W = 25;
   localparam int          DEPTH  = 16;
   localparam logic [24:0] BASE   = 25'h0001000;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        enable;
   logic        ce_pix;
   logic        hblank;
   logic        vblank;
   logic        mem_rd;
   logic [24:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_data;
   logic [7:0]  fg_r, fg_g, fg_b;
   logic [2:0]  mode;
   logic [7:0]  out_r, out_g, out_b;
   logic        underflow;

   always #5 clk_sys = ~clk_sys;

   overlay_fetch_blend #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .enable    (enable),
      .ce_pix    (ce_pix),
      .hblank    (hblank),
      .vblank    (vblank),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_data  (mem_data),
      .fg_r      (fg_r),
      .fg_g      (fg_g),
      .fg_b      (fg_b),
      .mode      (mode),
      .out_r     (out_r),
      .out_g     (out_g),
      .out_b     (out_b),
      .underflow (underflow)
   );

   int checks = 0;
   int errors = 0;

   // SDRAM model: picture words indexed from BASE, configurable latency.
   logic [15:0] mem_words [1024];
   int          mem_lat;
   logic        resp_en;
   int          flush_gen;
   int          nreq;
   logic [24:0] req_log [8192];

   function automatic logic [15:0] word_at(input logic [24:0] addr);
      logic [24:0] off;
      off = (addr - BASE) >> 1;
      return mem_words[off[9:0]];
   endfunction

   initial begin
      int          cnt;
      int          seen_gen;
      logic [24:0] req_addr;
      mem_ready = 1'b0;
      mem_data  = 16'h0000;
      nreq      = 0;
      cnt       = 0;
      seen_gen  = 0;
      req_addr  = BASE;
      forever begin
         @(posedge clk_sys);
         #1;
         mem_ready = 1'b0;
         if (flush_gen != seen_gen) begin
            cnt      = 0;
            seen_gen = flush_gen;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_ready = 1'b1;
               mem_data  = word_at(req_addr);
            end
         end
         if (mem_rd) begin
            req_log[nreq % 8192] = mem_addr;
            nreq++;
            req_addr = mem_addr;
            if (resp_en) cnt = mem_lat;
         end
      end
   end

   // Reference compositing from the pixel rules, per channel in integers.
   function automatic logic [23:0] ref_pix(input logic [15:0] w, input logic [7:0] fr,
                                           input logic [7:0] fgc, input logic [7:0] fb,
                                           input logic [2:0] m);
      logic [23:0] o;
      int a, c, f, base, res;
      a = int'(w[15:12]);
      o = '0;
      for (int ch = 0; ch < 3; ch++) begin
         c = (int'(w) >> (4 * ch)) & 15;
         f = (ch == 0) ? int'(fr) : (ch == 1) ? int'(fgc) : int'(fb);
         if ((fr | fgc | fb) == 8'h00) begin
            res = m[0] ? ((c * a * 17 + 128) / 256) * 17 : c * 17;
         end else begin
            base = (m[1] && (w[11:0] != 12'h000)) ? c * 17 : f;
            res  = base;
`ifdef OVERLAY_TINT_EN
            if (m[2] && fr > 8'd108) res = base + (255 - base) / 2 + (255 - base) / 4;
`endif
         end
         o[23 - 8 * ch -: 8] = res[7:0];
      end
      return o;
   endfunction

   task automatic do_reset();
      @(negedge clk_sys);
      reset  = 1'b1;
      flush_gen++;
      enable = 1'b0;
      ce_pix = 1'b0;
      hblank = 1'b0;
      vblank = 1'b0;
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      reset = 1'b0;
      flush_gen++;
      @(posedge clk_sys);
      #1;
   endtask

   // One ce_pix pixel, then 5 idle cycles; returns the output just after the
   // pixel edge and again at the end of the idle gap.
   task automatic pix(input logic hb, input logic vb, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic [2:0] m,
                      output logic [23:0] o_now, output logic [23:0] o_held);
      @(negedge clk_sys);
      hblank = hb; vblank = vb;
      fg_r = r; fg_g = g; fg_b = b; mode = m;
      ce_pix = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_pix = 1'b0;
      o_now = {out_r, out_g, out_b};
      repeat (5) @(posedge clk_sys);
      #1;
      o_held = {out_r, out_g, out_b};
   endtask

   task automatic test_reset();
      int n0;
      do_reset();
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
      checks++; if (mem_addr !== BASE) begin errors++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, BASE); end
      checks++; if ({out_r, out_g, out_b} !== 24'h0) begin errors++; $display("FAIL reset_out: got %h want 000000", {out_r, out_g, out_b}); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
      n0 = nreq;
      repeat (10) @(posedge clk_sys);
      #1;
      checks++; if (nreq != n0) begin errors++; $display("FAIL disabled_no_reads: got %0d reads want 0", nreq - n0); end
   endtask

   task automatic test_fill_stall();
      int n0, seen, bad;
      mem_lat = 3;
      resp_en = 1'b1;
      n0 = nreq;
      enable = 1'b1;
      @(posedge clk_sys);
      #1;
      checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL request_latency: got %b want 1", mem_rd); end
      repeat (120) @(posedge clk_sys);
      #1;
      checks++; if (nreq - n0 != DEPTH) begin errors++; $display("FAIL fill_reads: got %0d want %0d", nreq - n0, DEPTH); end
      checks++; if (mem_addr !== BASE + 25'(2 * DEPTH)) begin errors++; $display("FAIL fill_addr: got %h want %h", mem_addr, BASE + 25'(2 * DEPTH)); end
      bad = 0;
      for (int k = 0; k < DEPTH; k++)
         if (req_log[(n0 + k) % 8192] !== BASE + 25'(2 * k)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL fill_addr_seq: got %0d wrong addresses want 0", bad); end
      seen = 0;
      repeat (40) begin
         @(posedge clk_sys);
         #1;
         if (mem_rd) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL stall_no_rd: got %0d pulses want 0", seen); end
   endtask

   task automatic test_blend();
      logic [23:0] o, oh;
      mem_words[0] = 16'hF0F8;
      mem_words[1] = 16'h800F;
      mem_words[2] = 16'h000A;
      mem_words[3] = 16'h000A;
      pix(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      repeat (3) pix(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      pix(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b001, o, oh);
      checks++; if (o !== 24'h88FF00) begin errors++; $display("FAIL alpha_blend: got %h want 88ff00", o); end
      checks++; if (oh !== 24'h88FF00) begin errors++; $display("FAIL output_held: got %h want 88ff00", oh); end
      pix(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b001, o, oh);
      checks++; if (o !== 24'h880000) begin errors++; $display("FAIL alpha_half: got %h want 880000", o); end
      pix(1'b0, 1'b0, 8'h40, 8'h40, 8'h40, 3'b010, o, oh);
      checks++; if (o !== 24'hAA0000) begin errors++; $display("FAIL overlay_beam: got %h want aa0000", o); end
      pix(1'b0, 1'b0, 8'h80, 8'h40, 8'h40, 3'b110, o, oh);
`ifdef OVERLAY_TINT_EN
      checks++; if (o !== 24'hE9BEBE) begin errors++; $display("FAIL tint_beam: got %h want e9bebe", o); end
`else
      checks++; if (o !== 24'hAA0000) begin errors++; $display("FAIL tint_ignored: got %h want aa0000", o); end
`endif
   endtask

   task automatic test_random_frames();
      logic [23:0] o, oh, exp;
      logic        hb;
      logic [7:0]  r, g, b;
      logic [2:0]  m;
      int          j;
      for (int fr = 0; fr < 2; fr++) begin
         mem_lat = $urandom_range(1, 3);
         pix(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
         for (int k = 0; k < 64; k++) mem_words[k] = 16'($urandom);
         for (int k = 0; k < 4; k++) begin
            pix(1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 3'b000, o, oh);
            checks++; if (o !== 24'h0) begin errors++; $display("FAIL vblank_out: got %h want 000000", o); end
         end
         j = 0;
         for (int k = 0; k < 40; k++) begin
            hb = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) begin
               r = 8'h00; g = 8'h00; b = 8'h00;
            end else begin
               r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            end
            m = 3'($urandom);
            pix(hb, 1'b0, r, g, b, m, o, oh);
            if (hb) begin
               exp = 24'h0;
            end else begin
               exp = ref_pix(mem_words[j], r, g, b, m);
               j++;
            end
            checks++; if (o !== exp) begin errors++; $display("FAIL random_pixel: frame %0d px %0d got %h want %h", fr, k, o, exp); end
            checks++; if (oh !== exp) begin errors++; $display("FAIL random_held: frame %0d px %0d got %h want %h", fr, k, oh, exp); end
         end
      end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL no_underflow: got %b want 0", underflow); end
   endtask

   task automatic test_underflow();
      logic [23:0] o, oh;
      do_reset();
      resp_en = 1'b0;
      enable  = 1'b1;
      pix(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      checks++; if (o !== 24'h0) begin errors++; $display("FAIL underflow_out: got %h want 000000", o); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", underflow); end
      pix(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", underflow); end
   endtask

   task automatic test_restart_inflight();
      logic [23:0] o, oh, exp;
      int n0;
      do_reset();
      for (int k = 0; k < 8; k++) mem_words[k] = 16'($urandom) | 16'h0111;
      resp_en = 1'b1;
      mem_lat = 20;
      n0 = nreq;
      enable = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      checks++; if (nreq - n0 != 1) begin errors++; $display("FAIL inflight_one_read: got %0d want 1", nreq - n0); end
      pix(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      mem_lat = 1;
      repeat (5) pix(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      checks++; if (nreq - n0 < 2) begin errors++; $display("FAIL restart_reissue: got %0d reads want >=2", nreq - n0); end
      checks++; if (req_log[(n0 + 1) % 8192] !== BASE) begin errors++; $display("FAIL restart_addr: got %h want %h", req_log[(n0 + 1) % 8192], BASE); end
      for (int k = 0; k < 3; k++) begin
         pix(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b001, o, oh);
         exp = ref_pix(mem_words[k], 8'h00, 8'h00, 8'h00, 3'b001);
         checks++; if (o !== exp) begin errors++; $display("FAIL restart_pixel: px %0d got %h want %h", k, o, exp); end
      end
   endtask

   task automatic test_async_reset();
      logic [23:0] o, oh, exp;
      int n0, wait_cnt;
      resp_en = 1'b0;
      for (int k = 0; k < 40 && underflow !== 1'b1; k++)
         pix(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow: got %b want 1", underflow); end
      pix(1'b0, 1'b0, 8'h55, 8'h66, 8'h77, 3'b000, o, oh);
      checks++; if (o !== 24'h556677) begin errors++; $display("FAIL empty_fg_pixel: got %h want 556677", o); end
      @(negedge clk_sys);
      #1;
      reset = 1'b1;
      flush_gen++;
      #1;
      checks++; if ({out_r, out_g, out_b} !== 24'h0) begin errors++; $display("FAIL async_out: got %h want 000000", {out_r, out_g, out_b}); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL async_underflow: got %b want 0", underflow); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL async_mem_rd: got %b want 0", mem_rd); end
      checks++; if (mem_addr !== BASE) begin errors++; $display("FAIL async_addr: got %h want %h", mem_addr, BASE); end
      resp_en = 1'b1;
      mem_lat = 1;
      n0 = nreq;
      #1;
      reset = 1'b0;
      wait_cnt = 0;
      while (nreq == n0 && wait_cnt < 10) begin
         @(posedge clk_sys);
         #1;
         wait_cnt++;
      end
      checks++; if (nreq == n0) begin errors++; $display("FAIL async_refetch: got 0 reads want 1 within 10 cycles"); end
      checks++; if (req_log[n0 % 8192] !== BASE) begin errors++; $display("FAIL async_refetch_addr: got %h want %h", req_log[n0 % 8192], BASE); end
      repeat (20) @(posedge clk_sys);
      pix(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, o, oh);
      exp = ref_pix(mem_words[0], 8'h00, 8'h00, 8'h00, 3'b000);
      checks++; if (o !== exp) begin errors++; $display("FAIL async_first_pixel: got %h want %h", o, exp); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0;
      fg_r = 8'h00; fg_g = 8'h00; fg_b = 8'h00; mode = 3'b000;
      mem_lat = 3; resp_en = 1'b1; flush_gen = 0;
      for (int k = 0; k < 1024; k++) mem_words[k] = 16'($urandom);
      test_reset();
      test_fill_stall();
      test_blend();
      test_random_frames();
      test_underflow();
      test_restart_inflight();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
